// File: rtl/imem_boot_loader.sv
// Boot loader: streams a length-prefixed program into instruction memory, then releases the CPU from reset.
// Latency: one word written every 3 cycles with in_valid held high; cpu_rst_n rises on the cycle RUN is entered.
// Backpressure: in_ready is low in IDLE, WRITE, RUN, HALTED and ERROR; the source holds its byte until taken.
module imem_boot_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        im_wr,
  output logic [15:0] im_addr,
  output logic [15:0] im_data,
  output logic        cpu_rst_n,
  input  logic        cpu_hlt,
  output logic        load_done,
  output logic        halted,
  output logic        err,
  output logic [15:0] words_loaded
);

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_W_HI, S_W_LO, S_WRITE, S_RUN, S_HALTED, S_ERROR
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  n_hi;
  logic [15:0] n_words;
  logic [15:0] hdr_n;
  logic        take;
  logic        arm;

  assign take  = in_valid && in_ready;
  assign arm   = start && (state == S_IDLE || state == S_HALTED);
  assign hdr_n = {n_hi, in_data};

  // Status outputs are pure decodes of the state; ERROR is terminal so err is sticky.
  assign im_wr     = (state == S_WRITE);
  assign load_done = (state == S_RUN) || (state == S_HALTED);
  assign halted    = (state == S_HALTED);
  assign err       = (state == S_ERROR);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state decode and byte-accept handshake.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_HDR_HI;
      end
      S_HDR_HI: begin
        in_ready = 1'b1;
        if (in_valid) next_state = S_HDR_LO;
      end
      S_HDR_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (hdr_n == 16'd0)      next_state = S_RUN;
          else if (hdr_n > MAX_N)  next_state = S_ERROR;
          else                     next_state = S_W_HI;
        end
      end
      S_W_HI: begin
        in_ready = 1'b1;
        if (in_valid) next_state = S_W_LO;
      end
      S_W_LO: begin
        in_ready = 1'b1;
        if (in_valid) next_state = S_WRITE;
      end
      S_WRITE: begin
        next_state = (words_loaded + 16'd1 == n_words) ? S_RUN : S_W_HI;
      end
      S_RUN: begin
        if (cpu_hlt) next_state = S_HALTED;
      end
      S_HALTED: begin
        if (start) next_state = S_HDR_HI;
      end
      S_ERROR: begin
        next_state = S_ERROR;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Header capture, word assembly, address/count advance and the registered CPU reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_hi         <= 8'h00;
      n_words      <= 16'h0000;
      im_addr      <= 16'h0000;
      im_data      <= 16'h0000;
      words_loaded <= 16'h0000;
      cpu_rst_n    <= 1'b0;
    end else begin
      // Registered from next_state so release and re-arm both show on the first cycle of the new state.
      cpu_rst_n <= (next_state == S_RUN) || (next_state == S_HALTED);
      if (arm) begin
        words_loaded <= 16'h0000;
        im_addr      <= BASE_ADDR;
      end
      case (state)
        S_HDR_HI: if (take) n_hi <= in_data;
        S_HDR_LO: if (take) n_words <= hdr_n;
        S_W_HI:   if (take) im_data[15:8] <= in_data;
        S_W_LO:   if (take) im_data[7:0] <= in_data;
        S_WRITE: begin
          // Address wraps naturally at 16 bits.
          im_addr      <= im_addr + 16'd2;
          words_loaded <= words_loaded + 16'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed and randomized program loads against a queue-based write model.
// Latency: checks throughput spacing and the cycle on which cpu_rst_n releases.
// Backpressure: byte source holds each byte until it sees in_ready, with random idle gaps.
module tb_imem_boot_loader;

  localparam int BASE = 0;
  localparam int MAXW = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        cpu_hlt = 1'b0;
  logic        in_ready;
  logic        im_wr;
  logic [15:0] im_addr;
  logic [15:0] im_data;
  logic        cpu_rst_n;
  logic        load_done;
  logic        halted;
  logic        err;
  logic [15:0] words_loaded;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int viol = 0;
  logic [31:0] got_q[$];
  int          got_cyc[$];
  logic [15:0] words_q[$];

  imem_boot_loader #(.BASE_ADDR(16'(BASE)), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_wr(im_wr), .im_addr(im_addr), .im_data(im_data),
    .cpu_rst_n(cpu_rst_n), .cpu_hlt(cpu_hlt), .load_done(load_done), .halted(halted),
    .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Record every memory write and any cycle where the CPU is out of reset while loading.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (im_wr === 1'b1) begin
      got_q.push_back({im_addr, im_data});
      got_cyc.push_back(cyc);
    end
    if ((im_wr === 1'b1 || in_ready === 1'b1) && cpu_rst_n === 1'b1) viol <= viol + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_cyc.delete();
    viol = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    cpu_hlt = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    clear_mon();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte after a random gap and hold it until the loader takes it.
  task automatic send_byte(input logic [7:0] b, input int max_gap, input bit noise);
    int  g;
    bit  done;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    for (int i = 0; i < g; i++) begin
      if (noise) begin
        start   = 1'($urandom_range(1, 0));
        cpu_hlt = 1'($urandom_range(1, 0));
      end
      tick();
    end
    start = 1'b0;
    cpu_hlt = 1'b0;
    in_valid = 1'b1;
    in_data = b;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL send_byte: byte %h not taken, in_ready=%b required 1 within 50 cycles", b, in_ready);
    end
  endtask

  // Send header plus all of words_q, then wait for CPU release.
  task automatic load_words(input int max_gap, input bit noise);
    int n;
    bit up;
    n = words_q.size();
    send_byte(8'(n >> 8), max_gap, noise);
    send_byte(8'(n), max_gap, noise);
    foreach (words_q[i]) begin
      send_byte(words_q[i][15:8], max_gap, noise);
      send_byte(words_q[i][7:0], max_gap, noise);
    end
    up = 1'b0;
    for (int i = 0; i < 20 && !up; i++) begin
      if (cpu_rst_n === 1'b1) up = 1'b1;
      else tick();
    end
    tests++;
    if (!up) begin
      fails++;
      $display("FAIL load_release: cpu_rst_n=%b required 1 after load", cpu_rst_n);
    end
  endtask

  // Model: word i of the program lands at BASE + 2*i (mod 2^16).
  task automatic check_writes(input string name);
    logic [31:0] e;
    tests++;
    if (got_q.size() != words_q.size()) begin
      fails++;
      $display("FAIL %s write_count: got %0d required %0d", name, got_q.size(), words_q.size());
    end else begin
      foreach (words_q[i]) begin
        e = {16'(BASE + 2 * i), words_q[i]};
        tests++;
        if (got_q[i] !== e) begin
          fails++;
          $display("FAIL %s write[%0d]: got addr/data %h required %h", name, i, got_q[i], e);
        end
      end
    end
    tests++;
    if (viol != 0) begin
      fails++;
      $display("FAIL %s cpu_rst_n_during_load: got %0d violations required 0", name, viol);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    tests++;
    if ({in_ready, im_wr, cpu_rst_n, load_done, halted, err} !== 6'b0) begin
      fails++;
      $display("FAIL %s ctl_outputs: got %b required 000000", name,
               {in_ready, im_wr, cpu_rst_n, load_done, halted, err});
    end
    tests++;
    if ({im_addr, im_data, words_loaded} !== 48'h0) begin
      fails++;
      $display("FAIL %s data_outputs: got %h required 0", name, {im_addr, im_data, words_loaded});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL idle_in_ready: got %b required 0", in_ready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    pulse_start();
    words_q = '{16'hA123, 16'hB456};
    load_words(0, 1'b0);
    check_writes("basic");
    tests++;
    if (got_cyc.size() < 2 || got_cyc[1] - got_cyc[0] != 3) begin
      fails++;
      $display("FAIL basic throughput: got %0d writes / spacing wrong, required 2 writes 3 cycles apart",
               got_cyc.size());
    end
    tests++;
    if ({words_loaded, load_done, cpu_rst_n} !== {16'd2, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL basic status: words_loaded=%0d load_done=%b cpu_rst_n=%b required 2 1 1",
               words_loaded, load_done, cpu_rst_n);
    end
  endtask

  task automatic test_zero_count();
    do_reset();
    pulse_start();
    words_q.delete();
    load_words(0, 1'b0);
    check_writes("zero");
    tests++;
    if ({cpu_rst_n, load_done, in_ready, words_loaded} !== {1'b1, 1'b1, 1'b0, 16'd0}) begin
      fails++;
      $display("FAIL zero status: cpu_rst_n=%b load_done=%b in_ready=%b words_loaded=%0d required 1 1 0 0",
               cpu_rst_n, load_done, in_ready, words_loaded);
    end
  endtask

  task automatic test_error();
    bit rdy_seen;
    do_reset();
    pulse_start();
    send_byte(8'h04, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    tests++;
    if ({err, in_ready, cpu_rst_n, load_done} !== 4'b1000) begin
      fails++;
      $display("FAIL error entry: err/in_ready/cpu_rst_n/load_done got %b required 1000",
               {err, in_ready, cpu_rst_n, load_done});
    end
    pulse_start();
    cpu_hlt = 1'b1;
    in_valid = 1'b1;
    rdy_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || cpu_rst_n !== 1'b0) rdy_seen = 1'b1;
    end
    tick();
    in_valid = 1'b0;
    cpu_hlt = 1'b0;
    tests++;
    if (rdy_seen || err !== 1'b1 || halted !== 1'b0 || got_q.size() != 0) begin
      fails++;
      $display("FAIL error sticky: err=%b halted=%b ready_or_release_seen=%b writes=%0d required 1 0 0 0",
               err, halted, rdy_seen, got_q.size());
    end
    // Exactly MAX_WORDS must be accepted.
    do_reset();
    pulse_start();
    send_byte(8'h04, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    tests++;
    if (err !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL max_words boundary: err=%b in_ready=%b required 0 1", err, in_ready);
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      pulse_start();
      n = (it == 0) ? 3 : int'($urandom_range(6, 1));
      words_q.delete();
      for (int k = 0; k < n; k++) words_q.push_back(16'($urandom));
      load_words(3, 1'b1);
      check_writes("random");
      tests++;
      if (words_loaded !== 16'(n)) begin
        fails++;
        $display("FAIL random words_loaded: got %0d required %0d", words_loaded, n);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    pulse_start();
    words_q = '{16'hCAFE};
    load_words(0, 1'b0);
    check_writes("halt_first");
    cpu_hlt = 1'b1;
    tick();
    cpu_hlt = 1'b0;
    tick();
    tests++;
    if ({halted, load_done, cpu_rst_n} !== 3'b111) begin
      fails++;
      $display("FAIL halt entry: halted/load_done/cpu_rst_n got %b required 111", {halted, load_done, cpu_rst_n});
    end
    pulse_start();
    tests++;
    if ({cpu_rst_n, load_done, halted, in_ready} !== 4'b0001 || words_loaded !== 16'd0
        || im_addr !== 16'(BASE)) begin
      fails++;
      $display("FAIL rearm: cpu_rst_n/load_done/halted/in_ready=%b words_loaded=%0d im_addr=%h required 0001 0 %h",
               {cpu_rst_n, load_done, halted, in_ready}, words_loaded, im_addr, 16'(BASE));
    end
    clear_mon();
    words_q = '{16'h1234};
    load_words(0, 1'b0);
    check_writes("halt_reload");
    tests++;
    if (words_loaded !== 16'd1 || load_done !== 1'b1) begin
      fails++;
      $display("FAIL reload status: words_loaded=%0d load_done=%b required 1 1", words_loaded, load_done);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'hA1, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    repeat (3) tick();
    tests++;
    if (got_q.size() != 0) begin
      fails++;
      $display("FAIL async_reset writes: got %0d required 0", got_q.size());
    end
    rst_n = 1'b1;
    tick();
    clear_mon();
    pulse_start();
    words_q = '{16'h55AA};
    load_words(1, 1'b0);
    check_writes("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_error();
    test_random();
    test_halt();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
